// File: rtl/ecliptic_fcmp_pkg.sv
// Shared types and constants for the RV32F compare-class issuer.
package ecliptic_fcmp_pkg;

  typedef enum logic [2:0] {
    OP_FMIN = 3'd0,
    OP_FMAX = 3'd1,
    OP_FEQ  = 3'd2,
    OP_FLT  = 3'd3,
    OP_FLE  = 3'd4
  } fcmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } fcmp_state_e;

  localparam logic [31:0] CANONICAL_NAN = 32'h7fc0_0000;
  localparam int unsigned NV_BIT        = 4;

  function automatic logic op_is_legal(input logic [2:0] code);
    return code <= OP_FLE;
  endfunction

  function automatic logic [4:0] nv_fflags(input logic nv);
    logic [4:0] f;
    f         = '0;
    f[NV_BIT] = nv;
    return f;
  endfunction

endpackage

// File: rtl/ecliptic_nan_detect.sv
// Classifies an IEEE-754 single as NaN and, within that, signalling NaN.
module ecliptic_nan_detect (
  input  logic [31:0] value,
  output logic        is_nan,
  output logic        is_snan
);

  assign is_nan  = (value[30:23] == 8'hff) && (value[22:0] != 23'd0);
  assign is_snan = is_nan && !value[22];

endmodule

// File: rtl/ecliptic_fcmp_issuer.sv
// Issues one RV32F compare op at a time to the comparison unit, selects the
// result, raises NV, and falls back to a fixed result if the ack never comes.
module ecliptic_fcmp_issuer
  import ecliptic_fcmp_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_src1,
  input  logic [31:0] op_src2,
  output logic        cmp_req,
  output logic [31:0] cmp_src1,
  output logic [31:0] cmp_src2,
  input  logic [31:0] cmp_minimum,
  input  logic [31:0] cmp_maximum,
  input  logic        cmp_lt,
  input  logic        cmp_le,
  input  logic        cmp_eq,
  input  logic        cmp_ack,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_fflags,
  output logic        res_illegal,
  output logic        err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  fcmp_state_e state_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [2:0]  op_q;
  logic        nv_q;
  logic [7:0]  cnt_q;
  logic [31:0] res_data_q;
  logic [4:0]  res_fflags_q;
  logic        res_illegal_q;
  logic        err_q;

  logic        nan1, snan1, nan2, snan2;
  logic        nv_in;
  logic [31:0] ack_data;
  logic [31:0] timeout_data;

  ecliptic_nan_detect u_nan1 (.value(op_src1), .is_nan(nan1), .is_snan(snan1));
  ecliptic_nan_detect u_nan2 (.value(op_src2), .is_nan(nan2), .is_snan(snan2));

  // Ordered compares trap on any NaN; min/max/eq only on signalling NaNs.
  always_comb begin
    case (op_code)
      OP_FMIN, OP_FMAX, OP_FEQ: nv_in = snan1 | snan2;
      OP_FLT, OP_FLE:           nv_in = nan1 | nan2;
      default:                  nv_in = 1'b0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_FMIN: ack_data = cmp_minimum;
      OP_FMAX: ack_data = cmp_maximum;
      OP_FEQ:  ack_data = {31'b0, cmp_eq};
      OP_FLT:  ack_data = {31'b0, cmp_lt};
      OP_FLE:  ack_data = {31'b0, cmp_le};
      default: ack_data = '0;
    endcase
    timeout_data = (op_q == OP_FMIN || op_q == OP_FMAX) ? CANONICAL_NAN : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      src1_q        <= '0;
      src2_q        <= '0;
      op_q          <= '0;
      nv_q          <= 1'b0;
      cnt_q         <= '0;
      res_data_q    <= '0;
      res_fflags_q  <= '0;
      res_illegal_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            src1_q <= op_src1;
            src2_q <= op_src2;
            op_q   <= op_code;
            nv_q   <= nv_in;
            if (op_is_legal(op_code)) begin
              state_q <= ST_REQ;
            end else begin
              res_data_q    <= '0;
              res_fflags_q  <= '0;
              res_illegal_q <= 1'b1;
              state_q       <= ST_RESP;
            end
          end
        end
        ST_REQ: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // An ack on the final allowed cycle still takes priority over timeout.
          if (cmp_ack) begin
            res_data_q    <= ack_data;
            res_fflags_q  <= nv_fflags(nv_q);
            res_illegal_q <= 1'b0;
            state_q       <= ST_RESP;
          end else if (cnt_q == TIMEOUT_LAST) begin
            res_data_q    <= timeout_data;
            res_fflags_q  <= '0;
            res_illegal_q <= 1'b0;
            err_q         <= 1'b1;
            state_q       <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ready is held low for the whole reset window, not just after it.
  assign op_ready    = nrst && (state_q == ST_IDLE);
  assign cmp_req     = (state_q == ST_REQ);
  assign cmp_src1    = src1_q;
  assign cmp_src2    = src2_q;
  assign res_valid   = (state_q == ST_RESP);
  assign res_data    = res_data_q;
  assign res_fflags  = res_fflags_q;
  assign res_illegal = res_illegal_q;
  assign err         = err_q;

endmodule

// File: doc/ecliptic_fcmp_issuer.md
Name: ecliptic_fcmp_issuer

Overview: Initiator side of the FP comparison req/ack interface. Accepts RV32F compare-class ops (FMIN/FMAX/FEQ/FLT/FLE) from the FPU dispatch stage over valid/ready. Drives one single-cycle request to the comparison unit, collects its ack, and selects the result. Computes the NV exception flag and returns data plus fflags to writeback over valid/ready.

Parameters:
ACK_TIMEOUT, 8, max cycles spent in WAIT before abandoning the request (range 1..255)

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
op_valid  input  1  op offered by dispatch
op_ready  output  1  issuer can accept op
op_code  input  3  0 FMIN, 1 FMAX, 2 FEQ, 3 FLT, 4 FLE, 5-7 illegal
op_src1  input  32  IEEE-754 single operand 1
op_src2  input  32  IEEE-754 single operand 2
cmp_req  output  1  request pulse to comparison unit
cmp_src1  output  32  registered operand 1
cmp_src2  output  32  registered operand 2
cmp_minimum  input  32  comparator min result
cmp_maximum  input  32  comparator max result
cmp_lt  input  1  comparator less-than
cmp_le  input  1  comparator less-or-equal
cmp_eq  input  1  comparator equal
cmp_ack  input  1  comparator result valid
res_valid  output  1  result available
res_ready  input  1  writeback accepts result
res_data  output  32  result word
res_fflags  output  5  {NV,DZ,OF,UF,NX}; only NV ever set
res_illegal  output  1  op_code was 5-7
err  output  1  sticky: an ack timeout occurred

Behaviour:
- Async reset (nrst low): state IDLE, op_ready=0 during reset, all other outputs 0, operand/opcode registers 0, timeout counter 0, err=0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: op_ready=1. On op_valid&op_ready, register src1/src2/op_code and compute NV from the raw operands.
  - Legal op -> REQ.
  - Illegal op -> RESP with res_data=0, res_fflags=0, res_illegal=1, no cmp_req.
- REQ: cmp_req=1 for exactly one cycle. cmp_src1/cmp_src2 hold the registered operands from REQ until the next accept. Next state WAIT, counter cleared.
- WAIT: cmp_req=0.
  - cmp_ack=1: latch the selected result and go to RESP.
  - Otherwise increment the counter. When counter==ACK_TIMEOUT-1 without ack, go to RESP with timeout data, set err=1.
- Result select (on ack):
  - FMIN: cmp_minimum. FMAX: cmp_maximum.
  - FEQ/FLT/FLE: {31'b0, cmp_eq / cmp_lt / cmp_le}.
- Timeout data: FMIN/FMAX return 0x7fc00000; FEQ/FLT/FLE return 0. fflags are 0 and res_illegal=0.
- cmp_ack outside WAIT is ignored. Ack arriving in the same cycle as the timeout limit wins: normal result, err unchanged.
- NV rules:
  - NaN = exp==0xFF and mant!=0. sNaN = NaN and mant[22]==0.
  - FMIN/FMAX/FEQ: NV=1 if either operand is sNaN.
  - FLT/FLE: NV=1 if either operand is any NaN.
  - res_fflags = {NV,4'b0}.
- RESP: res_valid=1. res_data, res_fflags and res_illegal are stable while res_ready=0. On res_ready go to IDLE; res_valid drops next cycle.
- Throughput 1 op per 4 cycles; op_ready=0 outside IDLE. Latency: accept at cycle N -> cmp_req N+1 -> ack N+2 -> res_valid N+3 (comparator latency 1).
- err clears only on reset.
- Reset mid-operation abandons the op. No residual cmp_req or res_valid after reset release; a late ack is ignored because state is IDLE.

Decomposition:
- Package ecliptic_fcmp_pkg holds:
  - op_code enum (FMIN..FLE)
  - FSM state enum
  - CANONICAL_NAN = 32'h7fc00000
  - NV bit index 4
- Sub-module ecliptic_nan_detect: combinational, 32-bit input, outputs is_nan and is_snan. Instantiated twice, once per operand.

Test Plan:
- FLT src1=0x3f800000, src2=0x40000000 with a behavioural 1-cycle comparator -> cmp_req one cycle after accept; res_valid 3 cycles after accept; res_data=1, fflags=0.
- FEQ src1=0x7f800001 (sNaN), src2=0x3f800000 -> res_data=0, res_fflags=0x10. FEQ with qNaN 0x7fc00000 -> res_data=0, fflags=0.
- FLE src1=0x7fc00000, src2=0x00000000 -> res_data=0, res_fflags=0x10. FMIN src1=0x00000000, src2=0x80000000 -> res_data=0x80000000, fflags=0.
- Comparator never acks, ACK_TIMEOUT=8, op FMAX -> res_valid after 8 WAIT cycles; res_data=0x7fc00000, err=1 and stays 1 across later ops.
- res_ready held low 5 cycles in RESP -> res_data and fflags stable, op_ready=0, no second cmp_req. op_code=6 -> res_illegal=1, res_data=0, no cmp_req.
- nrst asserted during WAIT, ack arrives after release -> all outputs 0, state IDLE, ack ignored, next FMAX op completes normally.
